// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock and then
// releases the downstream domain resets in order, one STAGE_GAP apart.
module pll_reset_sequencer #(
   parameter int NUM_OUT        = 6,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int STABLE_CYCLES  = 256,
   parameter int STAGE_GAP      = 16,
   parameter int MAX_RETRY      = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               soft_reset,
   input  logic               pll_unlocked,
   output logic               pll_reset,
   output logic [NUM_OUT-1:0] domain_reset,
   output logic               ready,
   output logic               fail,
   output logic [3:0]         retry_cnt
);

   localparam int REL_CYCLES = STAGE_GAP * NUM_OUT;
   localparam int M1         = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int M2         = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
   localparam int CNT_MAX    = (M1 > M2) ? M1 : M2;
   localparam int CW         = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST     = CW'(REL_CYCLES - 1);
   localparam logic [3:0]    MAX_RETRY_C  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_OUT-1:0]   dom_q, dom_d;
   logic [3:0]           retry_q, retry_d;
   logic                 pll_reset_q, pll_reset_d;
   logic                 ready_q, ready_d;
   logic                 fail_q, fail_d;
   logic                 sync1_q, sync2_q;
   logic                 unl_s;

   // Two-flop synchronizer for the asynchronous unlocked flag; resets to "unlocked".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pll_unlocked;
         sync2_q <= sync1_q;
      end
   end

   assign unl_s = sync2_q;

   // Next-state, counter, retry and domain-reset logic; soft_reset outranks every event.
   always_comb begin
      state_d = state_q;
      dom_d   = dom_q;
      retry_d = retry_q;
      cnt_d   = cnt_q + CNT_ONE;
      if (soft_reset) begin
         state_d = ST_PLL_RST;
         dom_d   = '1;
         retry_d = 4'd0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
               else                       state_d = ST_PLL_RST;
            end
            ST_WAIT_LOCK: begin
               if (!unl_s) begin
                  state_d = ST_STABLE;
               end else if (cnt_q == LOCK_LAST) begin
                  if ((MAX_RETRY != 0) && (retry_q == MAX_RETRY_C)) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_PLL_RST;
                     retry_d = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
                  end
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end
            ST_STABLE: begin
               if (unl_s)                     state_d = ST_WAIT_LOCK;
               else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
               else                           state_d = ST_STABLE;
            end
            ST_RELEASE: begin
               if (unl_s) begin
                  state_d = ST_PLL_RST;
                  dom_d   = '1;
               end else begin
                  for (int k = 0; k < NUM_OUT; k++) begin
                     if (cnt_q == CW'(STAGE_GAP * (k + 1) - 1)) dom_d[k] = 1'b0;
                     else                                       dom_d[k] = dom_q[k];
                  end
                  if (cnt_q == REL_LAST) begin
                     state_d = ST_RUN;
                     retry_d = 4'd0;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end
            end
            ST_RUN: begin
               if (unl_s) begin
                  state_d = ST_PLL_RST;
                  dom_d   = '1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
               dom_d   = '1;
            end
            default: begin
               state_d = ST_PLL_RST;
               dom_d   = '1;
            end
         endcase
      end
      // Shared counter restarts on every state entry and idles in the terminal states.
      if (soft_reset || (state_d != state_q)) begin
         cnt_d = '0;
      end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
      pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      ready_d     = (state_d == ST_RUN);
      fail_d      = (state_d == ST_FAIL);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         dom_q       <= '1;
         retry_q     <= 4'd0;
         pll_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dom_q       <= dom_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_reset    = pll_reset_q;
   assign domain_reset = dom_q;
   assign ready        = ready_q;
   assign fail         = fail_q;
   assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer: per-cycle expected outputs are queued
// from the specified timing and compared one sample after each rising edge.
module tb_pll_reset_sequencer;

   localparam int P        = 4;
   localparam int T        = 20;
   localparam int S        = 8;
   localparam int G        = 3;
   localparam int N        = 3;
   localparam int R        = 2;
   localparam int LOCK_DLY = 10;

   typedef struct packed {
      logic         pr;
      logic [N-1:0] dr;
      logic         rdy;
      logic         fl;
      logic [3:0]   rc;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic         soft_reset;
   logic         pll_unlocked;
   logic         pll_reset;
   logic [N-1:0] domain_reset;
   logic         ready;
   logic         fail;
   logic [3:0]   retry_cnt;

   int   n_checks;
   int   n_errors;
   exp_t sb_q[$];

   pll_reset_sequencer #(
      .NUM_OUT(N), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T),
      .STABLE_CYCLES(S), .STAGE_GAP(G), .MAX_RETRY(R)
   ) dut (
      .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset), .pll_unlocked(pll_unlocked),
      .pll_reset(pll_reset), .domain_reset(domain_reset), .ready(ready), .fail(fail),
      .retry_cnt(retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input int n, input logic pr, input logic [N-1:0] dr,
                           input logic rdy, input logic fl, input logic [3:0] rc);
      exp_t e;
      e = {pr, dr, rdy, fl, rc};
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   task automatic sb_drain(input string tag);
      exp_t e;
      exp_t got;
      int   idx;
      idx = 0;
      while (sb_q.size() > 0) begin
         tick();
         e   = sb_q.pop_front();
         got = {pll_reset, domain_reset, ready, fail, retry_cnt};
         n_checks++;
         if (got !== e) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got pr=%b dr=%b rdy=%b fail=%b rc=%0d, expected pr=%b dr=%b rdy=%b fail=%b rc=%0d",
                     tag, idx, got.pr, got.dr, got.rdy, got.fl, got.rc, e.pr, e.dr, e.rdy, e.fl, e.rc);
         end
         idx++;
      end
   endtask

   // Starts one sample after PLL_RST entry with pll_unlocked high.
   task automatic bring_up(input logic [3:0] rc, input int glitch, input int stop_k);
      logic [N-1:0] dr;
      exp_push(P - 1, 1'b1, 3'b111, 1'b0, 1'b0, rc);
      exp_push(LOCK_DLY, 1'b0, 3'b111, 1'b0, 1'b0, rc);
      sb_drain("bringup_wait");
      pll_unlocked = 1'b0;
      if (glitch >= 0) begin
         exp_push(2 + glitch, 1'b0, 3'b111, 1'b0, 1'b0, rc);
         sb_drain("glitch_pre");
         pll_unlocked = 1'b1;
         exp_push(1, 1'b0, 3'b111, 1'b0, 1'b0, rc);
         sb_drain("glitch_pulse");
         pll_unlocked = 1'b0;
      end
      exp_push(2 + S + G, 1'b0, 3'b111, 1'b0, 1'b0, rc);
      sb_drain("bringup_stable");
      dr = 3'b111;
      for (int k = 0; k < stop_k; k++) begin
         dr[k] = 1'b0;
         if (k == N - 1)           exp_push(1, 1'b0, dr, 1'b1, 1'b0, 4'd0);
         else if (k == stop_k - 1) exp_push(1, 1'b0, dr, 1'b0, 1'b0, rc);
         else                      exp_push(G, 1'b0, dr, 1'b0, 1'b0, rc);
      end
      sb_drain("bringup_release");
   endtask

   task automatic pulse_soft_reset();
      soft_reset   = 1'b1;
      pll_unlocked = 1'b1;
      exp_push(1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0);
      sb_drain("soft_reset");
      soft_reset = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({pll_reset, domain_reset, ready, fail, retry_cnt} !== {1'b1, 3'b111, 1'b0, 1'b0, 4'd0}) begin
         n_errors++;
         $display("FAIL reset_values: got pr=%b dr=%b rdy=%b fail=%b rc=%0d, expected 1 111 0 0 0",
                  pll_reset, domain_reset, ready, fail, retry_cnt);
      end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_clean_bringup();
      bring_up(4'd0, -1, N);
   endtask

   task automatic test_lock_loss_run();
      pll_unlocked = 1'b1;
      exp_push(2, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0);
      exp_push(1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0);
      sb_drain("lock_loss_run");
      bring_up(4'd0, -1, N);
   endtask

   task automatic test_lock_glitch();
      pulse_soft_reset();
      bring_up(4'd0, 5, N);
   endtask

   task automatic test_no_lock();
      pulse_soft_reset();
      for (int a = 0; a <= R; a++) begin
         if (a == 0) exp_push(P - 1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0);
         else        exp_push(P, 1'b1, 3'b111, 1'b0, 1'b0, 4'(a));
         exp_push(T, 1'b0, 3'b111, 1'b0, 1'b0, 4'(a));
      end
      exp_push(4, 1'b1, 3'b111, 1'b0, 1'b1, 4'(R));
      sb_drain("no_lock");
   endtask

   task automatic test_soft_reset_fail();
      pulse_soft_reset();
      bring_up(4'd0, -1, N);
   endtask

   task automatic test_retry_then_lock();
      pulse_soft_reset();
      exp_push(P - 1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0);
      exp_push(T, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0);
      exp_push(1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd1);
      sb_drain("retry_timeout");
      bring_up(4'd1, -1, N);
   endtask

   task automatic test_async_reset_release();
      pulse_soft_reset();
      bring_up(4'd0, -1, 1);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({pll_reset, domain_reset, ready} !== {1'b1, 3'b111, 1'b0}) begin
         n_errors++;
         $display("FAIL async_reset: got pr=%b dr=%b rdy=%b, expected pr=1 dr=111 rdy=0",
                  pll_reset, domain_reset, ready);
      end
      pll_unlocked = 1'b1;
      tick();
      reset_n = 1'b1;
      bring_up(4'd0, -1, N);
   endtask

   initial begin
      reset_n      = 1'b0;
      soft_reset   = 1'b0;
      pll_unlocked = 1'b1;
      n_checks     = 0;
      n_errors     = 0;
      test_reset();
      test_clean_bringup();
      test_lock_loss_run();
      test_lock_glitch();
      test_no_lock();
      test_soft_reset_fail();
      test_retry_then_lock();
      test_async_reset_release();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have these parameters: NUM_OUT, 6, number of sequenced domain resets (1-6, one per PLL clock output).
REQ-002 SHALL have these parameters: PLL_RST_CYCLES, 16, clk cycles pll_reset is held high per attempt (>=1).
REQ-003 SHALL have these parameters: LOCK_TIMEOUT, 65535, clk cycles to wait for lock per attempt (>=2).
REQ-004 SHALL have these parameters: STABLE_CYCLES, 256, consecutive locked cycles required before release (>=1).
REQ-005 SHALL have these parameters: STAGE_GAP, 16, clk cycles between successive domain reset releases (>=1).
REQ-006 SHALL have these parameters: MAX_RETRY, 3, lock-timeout retries before FAIL (0 = retry forever, max 15).
REQ-007 SHALL have these ports: clk  in  1  single clock, free-running PLL reference clock.
REQ-008 SHALL have these ports: reset_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have these ports: soft_reset  in  1  synchronous, active-high restart request.
REQ-010 SHALL have these ports: pll_unlocked  in  1  PLL not-locked flag (inverted LOCKED), asynchronous to clk.
REQ-011 SHALL have these ports: pll_reset  out  1  active-high reset to the PLL.
REQ-012 SHALL have these ports: domain_reset  out  NUM_OUT  active-high per-domain resets; bit 0 is released first.
REQ-013 SHALL have these ports: ready  out  1  high when every domain reset is released.
REQ-014 SHALL have these ports: fail  out  1  high when retries are exhausted.
REQ-015 SHALL have these ports: retry_cnt  out  4  number of lock timeouts since the last RUN or restart.

Function
REQ-016 SHALL pass pll_unlocked through a 2-flop synchronizer; all rules below act on the synchronized value (unl_s).
REQ-017 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN and FAIL, using one shared cycle counter that is cleared on every state entry.
REQ-018 SHALL hold pll_reset high in PLL_RST and FAIL, and low in all other states; all outputs SHALL be registered.
REQ-019 SHALL move PLL_RST -> WAIT_LOCK after exactly PLL_RST_CYCLES cycles in PLL_RST.
REQ-020 SHALL move WAIT_LOCK -> STABLE in the cycle after unl_s is seen low.
REQ-021 SHALL treat LOCK_TIMEOUT cycles in WAIT_LOCK with unl_s high as a timeout. On timeout: if MAX_RETRY!=0 and retry_cnt==MAX_RETRY, go to FAIL; otherwise increment retry_cnt (saturating at 15) and go to PLL_RST.
REQ-022 SHALL, in STABLE, move to RELEASE after STABLE_CYCLES consecutive cycles of unl_s low; any cycle with unl_s high SHALL return to WAIT_LOCK with a fresh timeout window and no retry_cnt change.
REQ-023 SHALL, in RELEASE, clear domain_reset[k] STAGE_GAP*(k+1) cycles after RELEASE entry, for k=0..NUM_OUT-1.
REQ-024 SHALL move to RUN in the same cycle the last bit is cleared, set ready, and clear retry_cnt.
REQ-025 SHALL, on unl_s high in RELEASE or RUN (lock loss), on the next edge set all domain_reset bits, clear ready, and go to PLL_RST; retry_cnt SHALL be unchanged.
REQ-026 SHALL set fail and keep all domain_reset bits high in FAIL; FAIL SHALL be left only via soft_reset or reset_n.
REQ-027 SHALL, on soft_reset high in any state, on the next edge go to PLL_RST, set all domain_reset bits, and clear ready, fail and retry_cnt.
REQ-028 SHALL apply the priority soft_reset > lock loss > timeout > normal transition when events coincide.
REQ-029 SHALL keep domain_reset bits never re-asserted individually: they are released in order and re-asserted only all together.

Reset
REQ-030 SHALL, while reset_n is low, immediately and asynchronously set state=PLL_RST, counter=0, pll_reset=1, domain_reset=all ones, ready=0, fail=0, retry_cnt=0, and synchronizer flops=1.
REQ-031 SHALL, when reset_n is asserted mid-operation in any state, abort that operation and restart at PLL_RST after reset_n deasserts.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGE_GAP=3, NUM_OUT=3, MAX_RETRY=2)
REQ-032 SHALL cover clean bring-up: pll_unlocked falls 10 cycles after pll_reset drops -> STABLE entered 3 cycles later; domain_reset bits 0, 1, 2 clear at 3, 6 and 9 cycles after RELEASE entry; ready=1 with bit 2.
REQ-033 SHALL cover no lock: pll_unlocked held at 1 -> three 20-cycle WAIT_LOCK windows separated by 4-cycle pll_reset pulses; retry_cnt goes 1 then 2; fail=1 after the third timeout, with pll_reset=1 and domain_reset=3'b111.
REQ-034 SHALL cover a lock glitch: pll_unlocked pulses high for 1 cycle at STABLE cycle 5 -> back to WAIT_LOCK, domain_reset stays 3'b111, retry_cnt unchanged, and a full 8-cycle STABLE window is required again.
REQ-035 SHALL cover lock loss in RUN: pll_unlocked rises -> within 3 cycles domain_reset=3'b111 and ready=0, then pll_reset is high for 4 cycles and retry_cnt=0.
REQ-036 SHALL cover soft_reset in FAIL: one-cycle pulse -> next edge fail=0, retry_cnt=0, state=PLL_RST; then bring-up proceeds as in REQ-032.
REQ-037 SHALL cover reset_n asserted mid-RELEASE after bit 0 is cleared: domain_reset returns to 3'b111 and pll_reset=1 immediately, without waiting for a clk edge.
